// File: rtl/button_conditioner.sv
// button_conditioner: per-button sync, debounce, clean level and press/release strobes.
// Optional AUTO_REPEAT_EN adds held-button auto-repeat on btn_press.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int BTN_ACTIVE_LOW  = 0,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [N_BTN-1:0] s1, s2, diff, done, rise, fall, press_nxt;
    logic [CW-1:0]    cnt [N_BTN];
    assign diff = s2 ^ btn_level;
    assign rise = done & s2;
    assign fall = done & ~s2;
    always_comb begin
        done = '0;
        for (int i = 0; i < N_BTN; i++)
            done[i] = diff[i] && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            s1          <= '0;
            s2          <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            s1          <= btn_raw ^ {N_BTN{BTN_ACTIVE_LOW != 0}};
            s2          <= s1;
            btn_level   <= btn_level ^ done;
            btn_press   <= press_nxt;
            btn_release <= fall;
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= (diff[i] && !done[i]) ? cnt[i] + 1'b1 : '0;
        end
    end
`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0]    rcnt [N_BTN];
    logic [N_BTN-1:0] first, rep_hit;
    // first selects the initial delay; later repeats use the shorter period
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < N_BTN; i++)
            rep_hit[i] = btn_level[i] && !fall[i] &&
                (rcnt[i] == (first[i] ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
    end
    assign press_nxt = rise | rep_hit;
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            first <= '1;
            for (int i = 0; i < N_BTN; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                rcnt[i]  <= (!btn_level[i] || rep_hit[i]) ? '0 : rcnt[i] + 1'b1;
                first[i] <= !btn_level[i] ? 1'b1 : (rep_hit[i] ? 1'b0 : first[i]);
            end
        end
    end
`else
    assign press_nxt = rise;
`endif
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioner between the raw board push-buttons (reset, set_time, position_bt, change_bt) and the clock core.
- Per button: 2-FF synchroniser, debounce filter, clean debounced level, one-cycle press and release strobes.
- The clock core's state decode and edit counters consume the clean levels and strobes, instead of sampling bouncing pins against free-running counter bits.
- All buttons are handled independently by identical per-bit logic.

Parameters:
- N_BTN, 4, number of buttons handled.
- DEBOUNCE_CYCLES, 240000, cycles a synchronised input must differ from btn_level before btn_level follows (20 ms at 12 MHz); must be >= 2.
- BTN_ACTIVE_LOW, 0, 1 = raw pins read 0 when pressed; inverted before synchronisation.
- REPEAT_DELAY, 6000000, cycles from press strobe to first auto-repeat strobe (0.5 s); used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat strobes (0.1 s); used only with AUTO_REPEAT_EN.

Ports:
- CLK  input  1  system clock, 12 MHz nominal.
- reset_n  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  unsynchronised button pins.
- btn_level  output  N_BTN  debounced level, 1 = pressed.
- btn_press  output  N_BTN  one-cycle strobe on debounced press (plus repeat strobes when enabled).
- btn_release  output  N_BTN  one-cycle strobe on debounced release.

Behaviour:
- One clock (CLK). Reset is asynchronous, active-low (reset_n); every flop clears on reset_n low, independent of CLK.
- Reset values:
  - sync flops, btn_level, btn_press, btn_release all 0.
  - debounce and repeat counters all 0.
- Polarity: p = btn_raw XOR {N_BTN{BTN_ACTIVE_LOW}}. Sync chain: s1 <= p; s2 <= s1.
- Debounce per bit, counter width $clog2(DEBOUNCE_CYCLES):
  - s2 == btn_level: cnt <= 0.
  - s2 != btn_level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s2; cnt <= 0.
- Latency: a raw change stable from edge E updates btn_level at edge E+1+DEBOUNCE_CYCLES (2 sync edges, then DEBOUNCE_CYCLES-1 counting edges, counter at 0 for the first).
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronised cycles resets cnt and never reaches btn_level.
- Strobes:
  - btn_press[i] is registered; high for exactly the one cycle in which btn_level[i] first reads 1.
  - btn_release[i] is the same for the first cycle btn_level[i] reads 0.
  - press and release are never high together on the same bit.
- Simultaneous events: bits are fully independent. Multiple bits may strobe in the same cycle.
- No wrap: cnt saturates by design at DEBOUNCE_CYCLES-1 and then clears.
- Reset mid-debounce: partial count is discarded. After reset_n rises, a held button needs the full latency again and produces a fresh press strobe.
- Per-bit state (implicit): IDLE (level 0, s2 0) -> PRESS_QUAL (counting) -> HELD (level 1) -> REL_QUAL (counting) -> IDLE.
  - A disagreement in PRESS_QUAL returns to IDLE.
  - A disagreement in REL_QUAL returns to HELD.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Per-bit repeat counter, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1), cleared while btn_level == 0 and on the press strobe cycle.
  - While held, btn_press re-strobes for one cycle REPEAT_DELAY cycles after the press strobe, then every REPEAT_PERIOD cycles.
  - On release, repeating stops immediately and the counter clears; no repeat strobe coincides with btn_release.
- Not defined: repeat logic is not generated; exactly one btn_press per debounced press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=0):
- Reset: reset_n low 3 cycles with btn_raw=4'b1111 -> all outputs 0 while low; after release, btn_level=4'b1111 at 5th edge, btn_press=4'b1111 for one cycle.
- Clean press: btn_raw[0] 0->1 stable from edge E, held 20 cycles, then 0 -> btn_level[0]=1 and btn_press[0] pulse at E+5; btn_release[0] pulse and level 0 exactly 5 edges after the falling edge.
- Bounce: btn_raw[1] toggles 1,1,1,0,1,1,0 (periods < 4 cycles), then stable 1 -> no strobe during bouncing; single press strobe 5 edges after the last 0->1.
- Simultaneous: btn_raw[2] and [3] rise on the same edge -> identical level and strobe timing; [3] release during [2] hold does not affect [2].
- Reset mid-operation: btn_raw[0]=1 for 3 cycles, reset_n pulsed low, btn_raw held -> no strobe before reset; press strobe 5 edges after reset_n rises.
- Auto-repeat: hold btn_raw[0] 30 cycles; press strobe at P -> with AUTO_REPEAT_EN, strobes at P, P+10, P+13, P+16, … until release; without it, only P.
